// File: rtl/cordic_voice_sched.sv
// rtl/cordic_voice_sched.sv - time-multiplexed voice phase scheduler for a shared CORDIC sine unit
//
// Purpose: on each sample_tick, visits every voice in order, advances its
// quarter-turn phase by the LUT increment for its note, asks the shared
// CORDIC for the sine of (quadrant, phase), and sums the results into mix_out.
//
// Ports:
//   clock, reset            clock; asynchronous active-high reset
//   sample_tick             starts one sample; a tick while busy pulses overrun
//   voice_on[VOICES]        per-voice gate, sampled when the voice is visited
//   note_we/sel/data        note register write port
//   lut_note -> lut_inc     note of the current voice, increment returned same cycle
//   cordic_req/mode/angle   level request to the CORDIC, held until cordic_done
//   cordic_done/sin         completion pulse and signed result
//   mix_out, mix_valid      18-bit signed sum of active voices, one-cycle strobe
//   busy, overrun           sample in progress; ignored-tick pulse
//   timeout_err             voice aborted after TIMEOUT wait cycles
//
// Optional feature: define CORDIC_TIMEOUT_EN to enable the CORDIC wait timeout.
module cordic_voice_sched #(
    parameter int VOICES  = 4,
    parameter int MAX_INC = 102943,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic [VOICES-1:0]   voice_on,
    input  logic                note_we,
    input  logic [1:0]          note_sel,
    input  logic [7:0]          note_data,
    output logic [7:0]          lut_note,
    input  logic [14:0]         lut_inc,
    output logic                cordic_req,
    output logic [1:0]          cordic_mode,
    output logic [17:0]         cordic_angle,
    input  logic                cordic_done,
    input  logic signed [15:0]  cordic_sin,
    output logic signed [17:0]  mix_out,
    output logic                mix_valid,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int             IW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0]  LAST  = IW'(VOICES - 1);
    localparam logic [17:0]    MAX_W = 18'(MAX_INC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q;
    logic [17:0]        phase_q [VOICES];
    logic [1:0]         quad_q  [VOICES];
    logic [7:0]         note_q  [VOICES];
    logic signed [17:0] acc_q;
    logic signed [17:0] mix_q;
    logic               overrun_q;
    logic [17:0]        adv_sum;
    logic               adv_over;
    logic               wait_expire;

    // Phase stays below MAX_INC, and one increment is below MAX_INC, so a
    // single conditional subtraction is enough to wrap into the next quadrant.
    assign adv_sum  = phase_q[idx_q] + 18'(lut_inc);
    assign adv_over = (adv_sum >= MAX_W);

    assign lut_note     = note_q[idx_q];
    assign cordic_mode  = quad_q[idx_q];
    assign cordic_angle = phase_q[idx_q];
    assign mix_out      = mix_q;
    assign overrun      = overrun_q;

`ifdef CORDIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q;
    logic          timeout_q;

    assign wait_expire = (wait_cnt_q == CW'(TIMEOUT - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= (state_q == S_WAIT) && !cordic_done && wait_expire;
            if (state_q == S_REQ) begin
                wait_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end
        end
    end
`else
    assign wait_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cordic_req is decoded from the state register so that an asynchronous
    // reset removes it immediately and cordic_done drops it on the same edge.
    always_comb begin
        state_d    = state_q;
        cordic_req = 1'b0;
        busy       = 1'b1;
        mix_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (sample_tick) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                state_d = voice_on[idx_q] ? S_REQ : S_NEXT;
            end
            S_REQ: begin
                cordic_req = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                cordic_req = 1'b1;
                if (cordic_done || wait_expire) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = (idx_q == LAST) ? S_OUT : S_ADVANCE;
            end
            S_OUT: begin
                mix_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
                quad_q[i]  <= '0;
                note_q[i]  <= '0;
            end
            idx_q     <= '0;
            acc_q     <= '0;
            mix_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= sample_tick && (state_q != S_IDLE);
            // The LUT is read combinationally, so a write landing in a voice's
            // ADVANCE cycle is only seen on the next sample.
            if (note_we) begin
                note_q[note_sel] <= note_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (sample_tick) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                S_ADVANCE: begin
                    if (voice_on[idx_q]) begin
                        phase_q[idx_q] <= adv_over ? (adv_sum - MAX_W) : adv_sum;
                        if (adv_over) begin
                            quad_q[idx_q] <= quad_q[idx_q] + 2'd1;
                        end
                    end else begin
                        phase_q[idx_q] <= '0;
                        quad_q[idx_q]  <= '0;
                    end
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        acc_q <= acc_q + {{2{cordic_sin[15]}}, cordic_sin};
                    end
                end
                S_NEXT: begin
                    // Load mix_out on entry to OUT so it is already valid
                    // during the mix_valid strobe.
                    if (idx_q == LAST) begin
                        mix_q <= acc_q;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_voice_sched.sv
// tb/tb_cordic_voice_sched.sv - scoreboard bench for cordic_voice_sched
module tb_cordic_voice_sched;

    localparam int MAXI = 102943;
    localparam int TMO  = 64;

    logic               clock;
    logic               reset;
    logic               sample_tick;
    logic [3:0]         voice_on;
    logic               note_we;
    logic [1:0]         note_sel;
    logic [7:0]         note_data;
    logic [7:0]         lut_note;
    logic [14:0]        lut_inc;
    logic               cordic_req;
    logic [1:0]         cordic_mode;
    logic [17:0]        cordic_angle;
    logic               cordic_done;
    logic signed [15:0] cordic_sin;
    logic signed [17:0] mix_out;
    logic               mix_valid;
    logic               busy;
    logic               overrun;
    logic               timeout_err;

    cordic_voice_sched #(.VOICES(4), .MAX_INC(MAXI), .TIMEOUT(TMO)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .voice_on     (voice_on),
        .note_we      (note_we),
        .note_sel     (note_sel),
        .note_data    (note_data),
        .lut_note     (lut_note),
        .lut_inc      (lut_inc),
        .cordic_req   (cordic_req),
        .cordic_mode  (cordic_mode),
        .cordic_angle (cordic_angle),
        .cordic_done  (cordic_done),
        .cordic_sin   (cordic_sin),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [14:0] inc_tab [256];
    assign lut_inc = inc_tab[lut_note];

    int total = 0;
    int bad   = 0;

    int                 m_phase [4];
    int                 m_quad  [4];
    logic [7:0]         m_note  [4];
    logic signed [15:0] sin_tab [4];
    logic [19:0]        exp_req [$];
    logic signed [17:0] exp_mix [$];
    logic [17:0]        last_angle;
    logic [1:0]         last_mode;
    logic               seen_to;

    always @(negedge clock) if (timeout_err) seen_to <= 1'b1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_note(input int v, input logic [7:0] n);
        @(negedge clock);
        note_we = 1'b1; note_sel = 2'(v); note_data = n;
        @(negedge clock);
        note_we = 1'b0;
        m_note[v] = n;
    endtask

    task automatic run_sample(input logic [3:0] von, input int delay, input bit ovr,
                              input bit nwr, input logic [7:0] nwr_note, input int skipv);
        logic signed [17:0] sum;
        logic [19:0]        e;
        int                 n;
        bit                 ovr_pending;
        sum = '0;
        for (int v = 0; v < 4; v++) begin
            if (von[v]) begin
                m_phase[v] = m_phase[v] + int'(inc_tab[m_note[v]]);
                if (m_phase[v] >= MAXI) begin
                    m_phase[v] = m_phase[v] - MAXI;
                    m_quad[v]  = (m_quad[v] + 1) % 4;
                end
                exp_req.push_back({2'(m_quad[v]), 18'(m_phase[v])});
                if (v != skipv) sum = sum + 18'(sin_tab[v]);
            end else begin
                m_phase[v] = 0;
                m_quad[v]  = 0;
            end
        end
        exp_mix.push_back(sum);
        ovr_pending = ovr;

        @(negedge clock);
        voice_on = von; sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        chk("busy_after_tick", busy, 1);
        if (nwr) begin
            note_we = 1'b1; note_sel = 2'd0; note_data = nwr_note;
            @(negedge clock);
            note_we = 1'b0;
            m_note[0] = nwr_note;
        end

        for (int v = 0; v < 4; v++) begin
            if (von[v]) begin
                n = 0;
                while (!cordic_req && n < 200) begin
                    @(negedge clock);
                    n++;
                end
                if (!cordic_req) begin
                    chk("req_wait_expired", 0, 1);
                    return;
                end
                e = exp_req.pop_front();
                last_angle = cordic_angle;
                last_mode  = cordic_mode;
                chk("req_mode", cordic_mode, e[19:18]);
                chk("req_angle", cordic_angle, e[17:0]);
                chk("req_note", lut_note, m_note[v]);
                if (ovr_pending) begin
                    ovr_pending = 1'b0;
                    sample_tick = 1'b1;
                    @(negedge clock);
                    sample_tick = 1'b0;
                    chk("overrun_pulse", overrun, 1);
                    @(negedge clock);
                    chk("overrun_clear", overrun, 0);
                end
                if (v == skipv) begin
                    n = 0;
                    while (cordic_req && n < 200) begin
                        @(negedge clock);
                        n++;
                    end
                    chk("timeout_req_cycles", n, TMO + 1);
                    chk("timeout_err_pulse", timeout_err, 1);
                end else begin
                    repeat (delay) @(negedge clock);
                    chk("req_held", cordic_req, 1);
                    cordic_done = 1'b1; cordic_sin = sin_tab[v];
                    @(negedge clock);
                    cordic_done = 1'b0;
                    chk("req_drop", cordic_req, 0);
                end
            end
        end

        n = 0;
        while (!mix_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("mix_valid_seen", mix_valid, 1);
        chk("busy_at_valid", busy, 1);
        chk("mix_out", mix_out, exp_mix.pop_front());
        @(negedge clock);
        chk("mix_valid_one", mix_valid, 0);
        chk("busy_done", busy, 0);
        n = 0;
        repeat (4) begin
            @(negedge clock);
            if (mix_valid) n++;
        end
        chk("no_extra_valid", n, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) inc_tab[i] = 15'd0;
        inc_tab[1] = 15'd1000;
        inc_tab[2] = 15'd30000;
        inc_tab[3] = 15'd12345;
        inc_tab[4] = 15'd32767;
        inc_tab[5] = 15'd7;
        inc_tab[6] = 15'd25000;
        for (int v = 0; v < 4; v++) begin
            m_phase[v] = 0; m_quad[v] = 0; m_note[v] = 8'd0; sin_tab[v] = 16'sd0;
        end
        seen_to = 1'b0;
        reset = 1'b1; sample_tick = 1'b0; voice_on = 4'b0;
        note_we = 1'b0; note_sel = 2'd0; note_data = 8'd0;
        cordic_done = 1'b0; cordic_sin = 16'sd0;
        repeat (3) @(negedge clock);
        chk("rst_req", cordic_req, 0);
        chk("rst_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_mix", mix_out, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_angle", cordic_angle, 0);
        reset = 1'b0;

        // single voice, done two cycles into the request
        write_note(0, 8'd1);
        sin_tab[0] = 16'sh1234;
        run_sample(4'b0001, 2, 0, 0, 8'd0, -1);
        chk("single_angle_lit", last_angle, 1000);
        chk("single_mode_lit", last_mode, 0);
        chk("single_mix_lit", mix_out, 16'h1234);

        // stray done while idle is ignored; all voices off clears phase
        @(negedge clock);
        cordic_done = 1'b1; cordic_sin = 16'sd999;
        @(negedge clock);
        cordic_done = 1'b0;
        run_sample(4'b0000, 1, 0, 0, 8'd0, -1);

        // quadrant wrap: 4 x 30000 = 120000 -> 17057 in quadrant 1
        write_note(0, 8'd2);
        sin_tab[0] = 16'sd5;
        repeat (4) run_sample(4'b0001, 1, 0, 0, 8'd0, -1);
        chk("wrap_angle_lit", last_angle, 17057);
        chk("wrap_mode_lit", last_mode, 1);

        // all voices at full-scale positive and negative
        write_note(1, 8'd3);
        write_note(2, 8'd4);
        write_note(3, 8'd6);
        for (int v = 0; v < 4; v++) sin_tab[v] = 16'sd32767;
        run_sample(4'b1111, 1, 0, 0, 8'd0, -1);
        chk("full_pos_lit", mix_out, 131068);
        for (int v = 0; v < 4; v++) sin_tab[v] = -16'sd32768;
        run_sample(4'b1111, 1, 0, 0, 8'd0, -1);
        chk("full_neg_lit", mix_out, -131072);

        // partial gate, random results, tick during WAIT
        for (int v = 0; v < 4; v++) sin_tab[v] = 16'($urandom);
        run_sample(4'b1010, 3, 1, 0, 8'd0, -1);

        // note write in voice 0's ADVANCE cycle uses the old note this sample
        sin_tab[0] = 16'sd77;
        run_sample(4'b0001, 1, 0, 1, 8'd5, -1);
        run_sample(4'b0001, 1, 0, 0, 8'd0, -1);

`ifdef CORDIC_TIMEOUT_EN
        for (int v = 0; v < 4; v++) sin_tab[v] = 16'sd100;
        run_sample(4'b1111, 1, 0, 0, 8'd0, 2);
        chk("timeout_mix_lit", mix_out, 300);
`else
        chk("timeout_tied", seen_to, 0);
`endif

        // reset in the middle of a CORDIC wait
        @(negedge clock);
        voice_on = 4'b0001; sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        n = 0;
        while (!cordic_req && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("pre_reset_req", cordic_req, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", cordic_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mix", mix_out, 0);
        chk("mid_rst_note", lut_note, 0);
        chk("mid_rst_angle", cordic_angle, 0);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (mix_valid || cordic_req || busy) n++;
        end
        chk("post_rst_quiet", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
